alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Multi-cycle issue/writeback stage that sits directly upstream of the 8-bit ALU. It accepts one register-to-register instruction at a time over a valid/ready handshake and reads operands from a 4-entry, 8-bit register file. It drives the ALU's A, B and ALUSel inputs from registers, then writes the ALU's Result back and latches its ZFlag. It also provides a direct register load port and a debug read port.

## Interface
- NREG, 4: register-file depth; index width is fixed at 2 bits.
- DW, 8: datapath width; must equal the ALU width.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- InstrValid  in  1  instruction present.
- InstrReady  out  1  sequencer can accept; high only in IDLE.
- Opcode  in  3  forwarded to ALUSel (000 ADD, 001–011 SUB, 100 OR, 101 NOR, 110 AND, 111 XOR).
- Rd, Rs1, Rs2  in  2 each  destination and source register indices.
- ImmSel, Imm  in  1 / 8  B-operand immediate select and value; present only with ALU_SEQ_IMM_EN.
- LoadEn, LoadAddr, LoadData  in  1 / 2 / 8  direct register write; honoured only in IDLE.
- A, B  out  8 each  registered ALU operands.
- ALUSel  out  3  registered ALU opcode.
- Result  in  8  ALU result (combinational from A/B/ALUSel).
- ZFlag  in  1  ALU zero flag.
- Done  out  1  one-cycle pulse; writeback has completed.
- ZReg  out  1  zero flag of the last completed instruction.
- DbgAddr / DbgData  in 2 / out 8  combinational register-file read.

## Operation
- States are IDLE, EXEC and WB.
- IDLE: InstrReady=1.
  - On InstrValid&&InstrReady, latch A<=R[Rs1], B<=R[Rs2] (or Imm when ImmSel), ALUSel<=Opcode, and Rd; go to EXEC.
- EXEC: InstrReady=0; the ALU settles during the cycle.
  - At the closing edge: R[Rd]<=Result, ZReg<=ZFlag, Done<=1; go to WB.
- WB: Done=1, InstrReady=0; next state is IDLE unconditionally.
- Arithmetic is the ALU's, modulo 2^8. The sequencer never widens or saturates; carry and borrow are discarded.
- Rd may equal Rs1 or Rs2. Operands are captured at accept, so the writeback does not disturb the executing instruction.
- LoadEn in IDLE writes R[LoadAddr]<=LoadData. LoadEn in EXEC/WB is ignored (dropped, not queued).
- Load and accept in the same IDLE cycle: the accepted instruction's operands read the pre-load values, and the load still completes.
- InstrValid asserted outside IDLE is not accepted. The source must hold the instruction until InstrReady.
- Reset mid-EXEC or mid-WB: no writeback occurs, and the state returns to IDLE.

## Timing
- Reset values:
  - state=IDLE, InstrReady=1 from the first post-reset cycle.
  - A=B=0, ALUSel=000, Done=0, ZReg=0.
  - All R[i]=0, so DbgData=0.
- Accept at edge N, EXEC during cycle N+1, writeback at edge N+2.
- Done is high during cycle N+2, and InstrReady returns high in cycle N+3.
- Throughput is one instruction per 3 cycles. Back-to-back dependent instructions need no forwarding.
- DbgData reflects a writeback or load in the cycle after its edge.

## Configuration
- ALU_SEQ_IMM_EN defined: the ImmSel and Imm ports exist; ImmSel=1 selects Imm as B at accept.
- ALU_SEQ_IMM_EN undefined: the ImmSel and Imm ports are absent, and B is always R[Rs2].

## Structure
- Package alu_seq_pkg holds:
  - the opcode localparams (OP_ADD, OP_SUB, OP_OR, OP_NOR, OP_AND, OP_XOR);
  - the state encoding (IDLE, EXEC, WB);
  - the DW and NREG defaults.
- Sub-module alu_seq_regfile: 4×8 registers, one synchronous write port (writeback and load muxed, with writeback only in EXEC and load only in IDLE), two combinational operand reads and one debug read.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Load R1=0x05, R2=0x03; ADD Rd=0, Rs1=1, Rs2=2 -> A=0x05, B=0x03 in EXEC; Done 2 cycles after accept; R0=0x08, ZReg=0.
- SUB Rd=3, Rs1=1, Rs2=1 with R1=0x05 -> R3=0x00, ZReg=1; then OR of 0x05|0x03 -> 0x07, ZReg=0.
- Wrap-around: R1=0xFF, R2=0x01, ADD -> 0x00, ZReg=1; SUB with 0x00-0x01 -> 0xFF.
- Back-pressure: InstrValid held high through EXEC/WB -> InstrReady=0 there, exactly one accept per 3 cycles; LoadEn during EXEC does not change the register.
- Same-cycle load+accept of R1 with R1=0x05, LoadData=0x09, XOR R1^R1 -> result 0x00, then R1=0x09. With ALU_SEQ_IMM_EN, XOR R1 with Imm=0xFF at R1=0x05 -> 0xFA.
- rst asserted during EXEC -> no writeback, R[Rd] unchanged, Done never pulses, and InstrReady=1 on the cycle after reset releases.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU issue/writeback sequencer.
// Optional feature macro: ALU_SEQ_IMM_EN (immediate B operand).
package alu_seq_pkg;

    localparam int DW   = 8;   // datapath width, equals the ALU width
    localparam int NREG = 4;   // register-file depth
    localparam int AW   = 2;   // register index width

    // ALU opcodes as forwarded on ALUSel; 3'b010 and 3'b011 also select SUB.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef logic [DW-1:0] data_t;
    typedef logic [AW-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: instruction, load, ALU and debug signals of the sequencer.
// ImmSel/Imm exist only when ALU_SEQ_IMM_EN is defined.
interface alu_op_sequencer_if;
    import alu_seq_pkg::*;

    logic       InstrValid;
    logic       InstrReady;
    logic [2:0] Opcode;
    addr_t      Rd;
    addr_t      Rs1;
    addr_t      Rs2;
`ifdef ALU_SEQ_IMM_EN
    logic       ImmSel;
    data_t      Imm;
`endif
    logic       LoadEn;
    addr_t      LoadAddr;
    data_t      LoadData;
    data_t      A;
    data_t      B;
    logic [2:0] ALUSel;
    data_t      Result;
    logic       ZFlag;
    logic       Done;
    logic       ZReg;
    addr_t      DbgAddr;
    data_t      DbgData;

`ifdef ALU_SEQ_IMM_EN
    // Instruction source, ALU and debug host side.
    modport master (
        output InstrValid, Opcode, Rd, Rs1, Rs2, ImmSel, Imm,
        output LoadEn, LoadAddr, LoadData, Result, ZFlag, DbgAddr,
        input  InstrReady, A, B, ALUSel, Done, ZReg, DbgData
    );
    // Sequencer side.
    modport slave (
        input  InstrValid, Opcode, Rd, Rs1, Rs2, ImmSel, Imm,
        input  LoadEn, LoadAddr, LoadData, Result, ZFlag, DbgAddr,
        output InstrReady, A, B, ALUSel, Done, ZReg, DbgData
    );
`else
    // Instruction source, ALU and debug host side.
    modport master (
        output InstrValid, Opcode, Rd, Rs1, Rs2,
        output LoadEn, LoadAddr, LoadData, Result, ZFlag, DbgAddr,
        input  InstrReady, A, B, ALUSel, Done, ZReg, DbgData
    );
    // Sequencer side.
    modport slave (
        input  InstrValid, Opcode, Rd, Rs1, Rs2,
        input  LoadEn, LoadAddr, LoadData, Result, ZFlag, DbgAddr,
        output InstrReady, A, B, ALUSel, Done, ZReg, DbgData
    );
`endif

endinterface

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 4x8 register file, one synchronous write port,
// two combinational operand reads and one combinational debug read.
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  we,
    input  addr_t waddr,
    input  data_t wdata,
    input  addr_t raddr1,
    input  addr_t raddr2,
    input  addr_t dbg_addr,
    output data_t rdata1,
    output data_t rdata2,
    output data_t dbg_data
);

    data_t regs [NREG];

    // Write port; every register clears on reset.
    // NOTE: this storage is reset explicitly because software relies on R[i]=0
    // after reset; a larger RAM would normally be left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1   = regs[raddr1];
    assign rdata2   = regs[raddr2];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: three-state issue/writeback stage in front of the 8-bit ALU.
// Optional feature macro: ALU_SEQ_IMM_EN selects Imm as the B operand when ImmSel=1.
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    alu_op_sequencer_if.slave  bus
);

    state_t     state, state_nxt;
    logic       instr_ready;
    logic       accept;
    logic       wb_en;
    logic       load_ok;
    addr_t      rd_q;
    data_t      a_q, b_q;
    logic [2:0] alusel_q;
    logic       done_q;
    logic       zreg_q;
    data_t      rs1_data, rs2_data, b_sel;
    logic       rf_we;
    addr_t      rf_waddr;
    data_t      rf_wdata;

    // State register; reset returns to IDLE and abandons any pending writeback.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and per-state strobes.
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would infer a latch.
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        wb_en       = 1'b0;
        load_ok     = 1'b0;
        unique case (state)
            IDLE: begin
                instr_ready = 1'b1;
                load_ok     = bus.LoadEn;
                if (bus.InstrValid) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                wb_en     = 1'b1;
                state_nxt = WB;
            end
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ALU_SEQ_IMM_EN
    assign b_sel = bus.ImmSel ? bus.Imm : rs2_data;
`else
    assign b_sel = rs2_data;
`endif

    // Writeback (EXEC only) and direct load (IDLE only) never overlap.
    assign rf_we    = wb_en | load_ok;
    assign rf_waddr = wb_en ? rd_q       : bus.LoadAddr;
    assign rf_wdata = wb_en ? bus.Result : bus.LoadData;

    alu_seq_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr1   (bus.Rs1),
        .raddr2   (bus.Rs2),
        .dbg_addr (bus.DbgAddr),
        .rdata1   (rs1_data),
        .rdata2   (rs2_data),
        .dbg_data (bus.DbgData)
    );

    // Operand capture at accept, flag capture and Done pulse at writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            alusel_q <= OP_ADD;
            rd_q     <= '0;
            done_q   <= 1'b0;
            zreg_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q      <= rs1_data;
                b_q      <= b_sel;
                alusel_q <= bus.Opcode;
                rd_q     <= bus.Rd;
            end
            done_q <= wb_en;
            if (wb_en) zreg_q <= bus.ZFlag;
        end
    end

    assign bus.InstrReady = instr_ready;
    assign bus.A          = a_q;
    assign bus.B          = b_q;
    assign bus.ALUSel     = alusel_q;
    assign bus.Done       = done_q;
    assign bus.ZReg       = zreg_q;

endmodule
